// File: rtl/gpsdc_pkg.sv
// Shared types and constants for the GPS point transmitter that feeds the distance calculator.
// Holds the coordinate/distance widths, the FSM state encoding and the default parameter values.
package gpsdc_pkg;

    localparam int COORD_W        = 24;
    localparam int DIST_W         = 40;
    localparam int IDX_W          = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int GAP_CYC_DEF    = 2;
    localparam int TIMEOUT_DEF    = 1023;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_GAP,
        S_SEND,
        S_WAIT_VALID,
        S_ERR
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] lon;
        logic [COORD_W-1:0] lat;
    } coord_t;

endpackage

// File: rtl/gps_coord_fifo.sv
// Coordinate FIFO holding packed {lon, lat} entries; depth is a power of two.
// The head entry is visible combinationally on rd_data whenever the FIFO is not empty.
module gps_coord_fifo
    import gpsdc_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  coord_t wr_data,
    input  logic   pop,
    output coord_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    coord_t          mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    // A push while full is refused even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/gps_point_tx.sv
// Streams buffered GPS points to the distance calculator as DEN strobes and collects
// its Valid/D results, flagging a sticky error if a result never arrives.
module gps_point_tx
    import gpsdc_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int GAP_CYC    = GAP_CYC_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_lon,
    input  logic [COORD_W-1:0] in_lat,
    output logic               DEN,
    output logic [COORD_W-1:0] LON_IN,
    output logic [COORD_W-1:0] LAT_IN,
    input  logic               Valid,
    input  logic [DIST_W-1:0]  D,
    output logic               res_valid,
    output logic [DIST_W-1:0]  res_d,
    output logic [IDX_W-1:0]   res_idx,
    output logic               busy,
    output logic               timeout_err
);

    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state, state_d;
    logic [GW-1:0]  gap_cnt, gap_d;
    logic [TW-1:0]  tcnt, tcnt_d;
    logic           pop, den_d, cap, err_set;
    logic           full, empty;
    coord_t         wr_coord, head;

    assign wr_coord = '{lon: in_lon, lat: in_lat};
    assign in_ready = !full;

    gps_coord_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .wr_data (wr_coord),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            gap_cnt <= '0;
            tcnt    <= '0;
        end else begin
            state   <= state_d;
            gap_cnt <= gap_d;
            tcnt    <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state;
        gap_d   = '0;
        tcnt_d  = tcnt;
        pop     = 1'b0;
        den_d   = 1'b0;
        cap     = 1'b0;
        err_set = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) state_d = S_FIRST;
            end
            S_FIRST: begin
                pop     = 1'b1;
                den_d   = 1'b1;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (int'(gap_cnt) + 1 >= GAP_CYC) state_d = S_SEND;
                else                              gap_d   = gap_cnt + 1'b1;
            end
            S_SEND: begin
                tcnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    den_d   = 1'b1;
                    state_d = S_WAIT_VALID;
                end
            end
            S_WAIT_VALID: begin
                tcnt_d = tcnt + 1'b1;
                // A result arriving on the expiry cycle still counts as on time.
                if (Valid) begin
                    cap     = 1'b1;
                    state_d = S_SEND;
                end else if (int'(tcnt) + 1 >= TIMEOUT) begin
                    err_set = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            DEN         <= 1'b0;
            LON_IN      <= '0;
            LAT_IN      <= '0;
            res_valid   <= 1'b0;
            res_d       <= '0;
            res_idx     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            DEN       <= den_d;
            res_valid <= cap;
            busy      <= (state_d != S_IDLE) && (state_d != S_ERR);
            if (den_d) begin
                LON_IN <= head.lon;
                LAT_IN <= head.lat;
            end
            if (cap) begin
                res_d   <= D;
                res_idx <= res_idx + 1'b1;
            end
            if (err_set) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gps_point_tx.sv
// Directed bench for gps_point_tx: a table-driven point/result flow plus hand-written
// sequences for FIFO full, timeout, Valid-on-expiry and mid-operation reset.
module tb_gps_point_tx;
    import gpsdc_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [COORD_W-1:0] in_lon = '0;
    logic [COORD_W-1:0] in_lat = '0;
    logic               DEN;
    logic [COORD_W-1:0] LON_IN, LAT_IN;
    logic               Valid = 1'b0;
    logic [DIST_W-1:0]  D = '0;
    logic               res_valid;
    logic [DIST_W-1:0]  res_d;
    logic [IDX_W-1:0]   res_idx;
    logic               busy, timeout_err;

    gps_point_tx dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_lon      (in_lon),
        .in_lat      (in_lat),
        .DEN         (DEN),
        .LON_IN      (LON_IN),
        .LAT_IN      (LAT_IN),
        .Valid       (Valid),
        .D           (D),
        .res_valid   (res_valid),
        .res_d       (res_d),
        .res_idx     (res_idx),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] lon;
        logic [23:0] lat;
        logic [39:0] d;
        int          dly;
        logic [15:0] exp_idx;
    } vec_t;

    vec_t tbl[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        Valid    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_den"},       DEN,         0);
        check({tag, "_lon"},       LON_IN,      0);
        check({tag, "_lat"},       LAT_IN,      0);
        check({tag, "_res_valid"}, res_valid,   0);
        check({tag, "_res_d"},     res_d,       0);
        check({tag, "_res_idx"},   res_idx,     0);
        check({tag, "_busy"},      busy,        0);
        check({tag, "_terr"},      timeout_err, 0);
        check({tag, "_in_ready"},  in_ready,    1);
    endtask

    task automatic push(input logic [23:0] lon, input logic [23:0] lat);
        in_valid = 1'b1;
        in_lon   = lon;
        in_lat   = lat;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_den(output int w);
        w = 0;
        while (DEN !== 1'b1 && w < 64) begin
            tick();
            w++;
        end
        check("den_seen", DEN, 1);
    endtask

    task automatic next_den(output int w);
        tick();
        wait_den(w);
        w++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int den_cnt;
        int rv_cnt;

        tbl[0] = '{24'h0A0000, 24'h160000, 40'h0,             0, 16'd0};
        tbl[1] = '{24'h123456, 24'h654321, 40'h00_0000_1234, 20, 16'd1};
        tbl[2] = '{24'hFFFFFF, 24'h000001, 40'hFF_FFFF_FFFF,  0, 16'd2};
        tbl[3] = '{24'h800000, 24'h7FFFFF, 40'h80_0000_0001,  5, 16'd3};

        // Main flow: latency, Valid ignored in gap, spacing, results in order
        do_reset();
        check_idle("reset");
        push(tbl[0].lon, tbl[0].lat);
        wait_den(w);
        check("den_latency", w, 2);
        check("den1_lon", LON_IN, tbl[0].lon);
        check("den1_lat", LAT_IN, tbl[0].lat);
        check("den1_busy", busy, 1);
        Valid = 1'b1;
        D     = 40'hDE_AD00_BEEF;
        push(tbl[1].lon, tbl[1].lat);
        check("gap_res_valid_a", res_valid, 0);
        check("gap_den_a", DEN, 0);
        push(tbl[2].lon, tbl[2].lat);
        check("gap_res_valid_b", res_valid, 0);
        check("gap_den_b", DEN, 0);
        Valid = 1'b0;
        check("gap_res_idx", res_idx, 0);
        push(tbl[3].lon, tbl[3].lat);
        check("den2_spacing", DEN, 1);
        check("gap_res_idx_after", res_idx, 0);
        for (int i = 1; i < 4; i++) begin
            wait_den(w);
            check("den_follow", w, 0);
            check("den_lon", LON_IN, tbl[i].lon);
            check("den_lat", LAT_IN, tbl[i].lat);
            repeat (tbl[i].dly) tick();
            Valid = 1'b1;
            D     = tbl[i].d;
            tick();
            Valid = 1'b0;
            check("res_valid_pulse", res_valid, 1);
            check("res_d", res_d, tbl[i].d);
            check("res_idx", res_idx, tbl[i].exp_idx);
            check("den_not_adjacent", DEN, 0);
            tick();
            check("res_valid_once", res_valid, 0);
        end

        // FIFO full: four pushes fill it while waiting for a result, fifth stalls
        do_reset();
        push(24'h0000AA, 24'h0000BB);
        push(24'h0000CC, 24'h0000DD);
        wait_den(w);
        next_den(w);
        for (int k = 0; k < 4; k++) begin
            check("fill_ready", in_ready, 1);
            push(24'h100000 + 24'(k), 24'h200000 + 24'(k));
        end
        check("full_not_ready", in_ready, 0);
        in_valid = 1'b1;
        in_lon   = 24'h100004;
        in_lat   = 24'h200004;
        repeat (3) begin
            tick();
            check("full_stall", in_ready, 0);
        end
        Valid = 1'b1;
        D     = 40'h55;
        tick();
        Valid = 1'b0;
        check("full_res_valid", res_valid, 1);
        check("full_still_full", in_ready, 0);
        tick();
        check("pop_frees_slot", in_ready, 1);
        check("pop_den", DEN, 1);
        check("pop_order_lon", LON_IN, 24'h100000);
        tick();
        in_valid = 1'b0;
        check("fifth_accepted", in_ready, 0);

        // Timeout: no Valid for TIMEOUT cycles after the second DEN
        do_reset();
        push(24'h000111, 24'h000222);
        push(24'h000333, 24'h000444);
        wait_den(w);
        next_den(w);
        check("to_den2_lon", LON_IN, 24'h000333);
        repeat (1022) tick();
        check("to_not_yet", timeout_err, 0);
        check("to_busy_wait", busy, 1);
        tick();
        check("to_err", timeout_err, 1);
        check("to_busy_err", busy, 0);
        for (int k = 0; k < 4; k++) push(24'h300000 + 24'(k), 24'h400000 + 24'(k));
        check("err_fifo_full", in_ready, 0);
        den_cnt = 0;
        rv_cnt  = 0;
        Valid   = 1'b1;
        D       = 40'h1;
        repeat (20) begin
            tick();
            den_cnt += int'(DEN);
            rv_cnt  += int'(res_valid);
        end
        Valid = 1'b0;
        check("err_no_den", den_cnt, 0);
        check("err_no_res", rv_cnt, 0);
        check("err_sticky", timeout_err, 1);
        check("err_res_idx", res_idx, 0);

        // Valid on the expiry cycle wins over the timeout
        do_reset();
        push(24'h000555, 24'h000666);
        push(24'h000777, 24'h000888);
        wait_den(w);
        next_den(w);
        repeat (1022) tick();
        Valid = 1'b1;
        D     = 40'h777;
        tick();
        Valid = 1'b0;
        check("edge_res_valid", res_valid, 1);
        check("edge_res_d", res_d, 40'h777);
        check("edge_res_idx", res_idx, 1);
        check("edge_no_err", timeout_err, 0);
        check("edge_busy", busy, 1);

        // Reset during S_WAIT_VALID with two entries queued
        do_reset();
        push(24'h0A0A0A, 24'h0B0B0B);
        push(24'h0C0C0C, 24'h0D0D0D);
        wait_den(w);
        next_den(w);
        push(24'h0E0E0E, 24'h0F0F0F);
        push(24'h111111, 24'h222222);
        reset = 1'b1;
        tick();
        check_idle("mid_reset");
        reset   = 1'b0;
        den_cnt = 0;
        repeat (10) begin
            tick();
            den_cnt += int'(DEN);
        end
        check("mid_no_den", den_cnt, 0);
        check("mid_busy", busy, 0);
        check("mid_ready", in_ready, 1);
        push(24'h333333, 24'h444444);
        wait_den(w);
        check("mid_latency", w, 2);
        check("mid_new_lon", LON_IN, 24'h333333);
        check("mid_new_lat", LAT_IN, 24'h444444);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gps_point_tx.md
GPS_POINT_TX -- requirements
Module: gps_point_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of coordinate entries buffered; power of two, 2 to 16.
REQ-002 Parameter GAP_CYC, default 2: idle cycles between the first and second DEN pulses.
REQ-003 Parameter TIMEOUT, default 1023: maximum cycles to wait for Valid after a DEN pulse.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream coordinate push request.
REQ-007 in_ready  out  1  FIFO can accept a push (not full).
REQ-008 in_lon  in  24  longitude to push.
REQ-009 in_lat  in  24  latitude to push.
REQ-010 DEN  out  1  one-cycle strobe marking a valid point on LON_IN/LAT_IN.
REQ-011 LON_IN  out  24  longitude driven to the distance calculator.
REQ-012 LAT_IN  out  24  latitude driven to the distance calculator.
REQ-013 Valid  in  1  distance-calculator result strobe.
REQ-014 D  in  40  distance-calculator result, sampled when Valid is high.
REQ-015 res_valid  out  1  one-cycle strobe for a captured result.
REQ-016 res_d  out  40  captured distance.
REQ-017 res_idx  out  16  result count, 1-based, wrapping at 65535 to 0.
REQ-018 busy  out  1  high in every state except S_IDLE and S_ERR.
REQ-019 timeout_err  out  1  sticky flag indicating a Valid timeout.

Function
REQ-020 Push SHALL occur when in_valid and in_ready are both high; in_ready SHALL equal !full, with no push-through on a simultaneous pop while full.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and an entry count SHALL distinguish full from empty.
REQ-022 The FSM SHALL have the states S_IDLE, S_FIRST, S_GAP, S_SEND, S_WAIT_VALID and S_ERR.
REQ-023 S_IDLE SHALL transition to S_FIRST when the FIFO is non-empty.
REQ-024 S_FIRST SHALL pop the FIFO head, drive DEN=1 with that head on LON_IN/LAT_IN in the next cycle, and transition to S_GAP.
REQ-025 S_GAP SHALL count GAP_CYC cycles and then transition to S_SEND.
REQ-026 S_SEND SHALL wait while the FIFO is empty; otherwise it SHALL pop, pulse DEN with the popped point, clear the timeout counter and transition to S_WAIT_VALID.
REQ-027 On Valid=1, S_WAIT_VALID SHALL register D into res_d, increment res_idx, pulse res_valid in the following cycle and transition to S_SEND.
REQ-028 Valid SHALL be ignored in every state other than S_WAIT_VALID.
REQ-029 In S_WAIT_VALID the timeout counter SHALL increment each cycle; on reaching TIMEOUT without Valid, it SHALL set timeout_err and transition to S_ERR.
REQ-030 If Valid arrives in the same cycle the counter reaches TIMEOUT, Valid SHALL win.
REQ-031 S_ERR SHALL be terminal until reset, with DEN held at 0; pushes SHALL still be accepted until the FIFO is full.
REQ-032 DEN SHALL be high for exactly one cycle per popped point, and no two DEN pulses SHALL be adjacent.
REQ-033 LON_IN/LAT_IN SHALL hold their last driven value while DEN=0.
REQ-034 Latency from a push into an empty FIFO in S_IDLE to DEN SHALL be exactly 2 cycles.
REQ-035 All outputs except in_ready SHALL be registered.

Reset
REQ-036 Reset SHALL set the FSM to S_IDLE, FIFO empty, in_ready=1, DEN=0, LON_IN=0, LAT_IN=0, res_valid=0, res_d=0, res_idx=0, busy=0, timeout_err=0, and all counters to 0.
REQ-037 Reset asserted mid-operation SHALL discard FIFO contents and any pending result, and SHALL take priority over every other event in that cycle.

Structure
REQ-038 The state encoding, COORD_W=24, DIST_W=40 and default parameter values SHALL reside in the shared package gpsdc_pkg.
REQ-039 The FIFO SHALL be a separate sub-module, gps_coord_fifo (48-bit entries, parameterized depth).

Verification
REQ-040 Reset then push (0x0A0000,0x160000): DEN=1 exactly 2 cycles after the push with LON_IN=0x0A0000 and LAT_IN=0x160000, then busy=1.
REQ-041 Push 3 points, then model Valid with D=0x00_0000_1234 20 cycles after the second DEN: res_valid pulses once with res_d=0x1234 and res_idx=1, and the third DEN follows.
REQ-042 Push 5 points with FIFO_DEPTH=4 and no pops: in_ready=0 after 4 accepted pushes, and the fifth push stalls until the first pop.
REQ-043 After the second DEN, withhold Valid for 1023 cycles: timeout_err=1, state S_ERR, busy=0, and no further DEN until reset.
REQ-044 Assert Valid while in S_GAP: res_valid stays 0 and res_idx stays 0.
REQ-045 Assert reset during S_WAIT_VALID with 2 entries queued: all outputs return to reset values, in_ready=1, and no DEN occurs until a new push.
